// File: rtl/fpu_issue_sched.sv
// fpu_issue_sched: round-robin issue scheduler for the FP execute cluster.
// Shares a fixed-latency pipelined FPU and an iterative divide/sqrt unit
// between NREQ requesters. At most one grant is made per cycle, and the single
// FP writeback bus slot is reserved at grant time.
// Optional build macro FPU_SCHED_STATS_EN adds the stat_grants and
// stat_wb_conflict counters; leaving it undefined removes the ports and the
// counters without changing scheduling behaviour.

// Per-requester eligibility slice
module fpu_issue_elig (
    input  logic i_val,        // requester has an op ready
    input  logic i_is_div,     // op targets the divide/sqrt unit
    input  logic i_open,       // out of reset and not flushed
    input  logic i_pipe_free,  // writeback slot at t+LAT is free
    input  logic i_div_free,   // divider idle and slot at t+DIV_LAT is free
    output logic o_elig,       // may be granted this cycle
    output logic o_blk         // valid, but held off only by a reservation or busy divider
);
    logic w_unit_free;

    assign w_unit_free = i_is_div ? i_div_free : i_pipe_free;
    assign o_elig      = i_val & i_open & w_unit_free;
    assign o_blk       = i_val & i_open & ~w_unit_free;
endmodule

module fpu_issue_sched #(
    parameter int NREQ    = 4,
    parameter int LAT     = 4,
    parameter int DIV_LAT = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_val,
    input  logic [NREQ-1:0]         req_is_div,
    input  logic                    flush,
    output logic [NREQ-1:0]         req_gnt,
    output logic                    issue_val,
    output logic [$clog2(NREQ)-1:0] issue_idx,
    output logic                    issue_is_div,
    output logic                    div_busy,
`ifdef FPU_SCHED_STATS_EN
    output logic [31:0]             stat_grants,
    output logic [31:0]             stat_wb_conflict,
`endif
    output logic                    wb_div_sel
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(DIV_LAT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [IW-1:0]      r_rr_ptr;
    logic [DIV_LAT:1]   r_resv;       // bit k set: writeback bus taken k cycles from now
    logic [DIV_LAT:1]   w_resv_nxt;
    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;

    logic               w_open;
    logic               w_pipe_free;
    logic               w_div_free;
    logic [NREQ-1:0]    w_elig;
    logic [NREQ-1:0]    w_blk;
    logic               w_gnt_any;
    logic [IW-1:0]      w_gnt_idx;
    logic               w_gnt_div;
    logic               w_pipe_gnt;
    logic               w_div_gnt;

    // Reset held low also blocks grants, so nothing issues while reset is asserted.
    assign w_open      = reset & ~flush;
    assign w_pipe_free = ~r_resv[LAT];
    assign w_div_free  = (r_state == S_IDLE) & ~r_resv[DIV_LAT];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            fpu_issue_elig u_elig (
                .i_val       (req_val[gi]),
                .i_is_div    (req_is_div[gi]),
                .i_open      (w_open),
                .i_pipe_free (w_pipe_free),
                .i_div_free  (w_div_free),
                .o_elig      (w_elig[gi]),
                .o_blk       (w_blk[gi])
            );
        end
    endgenerate

    // Round-robin pick: first eligible requester starting at r_rr_ptr
    always_comb begin
        int idx;
        idx       = 0;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(r_rr_ptr) + off) % NREQ;
            if (!w_gnt_any && w_elig[idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = IW'(idx);
            end
        end
    end

    assign w_gnt_div    = req_is_div[w_gnt_idx];
    assign w_pipe_gnt   = w_gnt_any & ~w_gnt_div;
    assign w_div_gnt    = w_gnt_any & w_gnt_div;

    assign req_gnt      = w_gnt_any ? (NREQ'(1) << w_gnt_idx) : '0;
    assign issue_val    = w_gnt_any;
    assign issue_idx    = w_gnt_idx;
    assign issue_is_div = w_div_gnt;
    assign div_busy     = (r_state != S_IDLE);
    assign wb_div_sel   = (r_state == S_WB);

    // Next reservation vector: age every slot by one, then book the granted op's
    // writeback. Stored one cycle later, so slot t+L lands in bit L-1. A LAT of 1
    // has nothing to book: no later grant can collide with a slot one cycle out.
    always_comb begin
        w_resv_nxt = {1'b0, r_resv[DIV_LAT:2]};
        for (int k = 1; k <= DIV_LAT; k++) begin
            if (w_pipe_gnt && (k == LAT - 1))
                w_resv_nxt[k] = 1'b1;
            if (w_div_gnt && (k == DIV_LAT - 1))
                w_resv_nxt[k] = 1'b1;
        end
    end

    // Round-robin pointer and reservation vector
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= '0;
            r_resv   <= '0;
        end else begin
            r_resv <= w_resv_nxt;
            if (w_gnt_any)
                r_rr_ptr <= (w_gnt_idx == IW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // Divide/sqrt FSM: grant at t -> RUN from t+1 -> WB exactly at t+DIV_LAT -> IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_div_gnt) begin
                        r_state <= S_RUN;
                        r_cnt   <= CW'(DIV_LAT - 2);
                    end
                end
                S_RUN: begin
                    if (r_cnt == '0)
                        r_state <= S_WB;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                S_WB:    r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef FPU_SCHED_STATS_EN
    logic [31:0] r_stat_grants;
    logic [31:0] r_stat_wb_conflict;

    // Grant and writeback-conflict counters, both wrap naturally at 2^32
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_grants      <= '0;
            r_stat_wb_conflict <= '0;
        end else begin
            if (w_gnt_any)
                r_stat_grants <= r_stat_grants + 32'd1;
            if (|w_blk)
                r_stat_wb_conflict <= r_stat_wb_conflict + 32'd1;
        end
    end

    assign stat_grants      = r_stat_grants;
    assign stat_wb_conflict = r_stat_wb_conflict;
`endif

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Directed bench for fpu_issue_sched (NREQ=4, LAT=4, DIV_LAT=12).
// Inputs change 1ns after posedge; outputs are sampled on the negedge.
module tb_fpu_issue_sched;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req_val = '0;
    logic [3:0] req_is_div = '0;
    logic       flush = 1'b0;
    logic [3:0] req_gnt;
    logic       issue_val;
    logic [1:0] issue_idx;
    logic       issue_is_div;
    logic       div_busy;
    logic       wb_div_sel;
`ifdef FPU_SCHED_STATS_EN
    logic [31:0] stat_grants;
    logic [31:0] stat_wb_conflict;
`endif

    int n_vec = 0;
    int n_err = 0;

    fpu_issue_sched #(.NREQ(4), .LAT(4), .DIV_LAT(12)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_val      (req_val),
        .req_is_div   (req_is_div),
        .flush        (flush),
        .req_gnt      (req_gnt),
        .issue_val    (issue_val),
        .issue_idx    (issue_idx),
        .issue_is_div (issue_is_div),
        .div_busy     (div_busy),
`ifdef FPU_SCHED_STATS_EN
        .stat_grants      (stat_grants),
        .stat_wb_conflict (stat_wb_conflict),
`endif
        .wb_div_sel   (wb_div_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold reset for one cycle; returns just after releasing it at the start of cycle 0
    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b0; req_val = '0; req_is_div = '0; flush = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        // Reset held low with all requesters valid: nothing may issue
        req_val = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt",  32'(req_gnt),    32'h0);
        chk("rst_ival", 32'(issue_val),  32'h0);
        chk("rst_busy", 32'(div_busy),   32'h0);
        chk("rst_wb",   32'(wb_div_sel), 32'h0);

        // Release with 4'hF held: back-to-back pipe grants 0,1,2,3,0
        @(posedge clk); #1;
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            chk($sformatf("rr_gnt_c%0d", c), 32'(req_gnt),      32'(4'h1 << (c % 4)));
            chk($sformatf("rr_idx_c%0d", c), 32'(issue_idx),    32'(c % 4));
            chk($sformatf("rr_div_c%0d", c), 32'(issue_is_div), 32'h0);
        end

        // Div from req1 at 0; pipe req0 at 8 is blocked by the div writeback at 12
        pulse_reset();
        for (int c = 0; c <= 13; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            req_val    = (c == 0) ? 4'h2 : ((c == 8 || c == 9) ? 4'h1 : 4'h0);
            req_is_div = (c == 0) ? 4'h2 : 4'h0;
            @(negedge clk);
            chk($sformatf("d1_busy_c%0d", c), 32'(div_busy),   32'(c >= 1 && c <= 12));
            chk($sformatf("d1_wb_c%0d", c),   32'(wb_div_sel), 32'(c == 12));
            chk($sformatf("d1_ival_c%0d", c), 32'(issue_val),  32'(c == 0 || c == 9));
            if (c == 0) begin
                chk("d1_idx_c0", 32'(issue_idx),    32'd1);
                chk("d1_isd_c0", 32'(issue_is_div), 32'd1);
            end
            if (c == 9) begin
                chk("d1_gnt_c9", 32'(req_gnt),      32'h1);
                chk("d1_isd_c9", 32'(issue_is_div), 32'd0);
            end
`ifdef FPU_SCHED_STATS_EN
            if (c == 10) begin
                chk("st_grants_c10",   stat_grants,      32'd2);
                chk("st_conflict_c10", stat_wb_conflict, 32'd1);
            end
`endif
        end

        // Second div from req3 arriving at 3 waits for the divider, issues at 13, writes back at 25
        pulse_reset();
        for (int c = 0; c <= 26; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            req_val    = (c == 0) ? 4'h2 : ((c >= 3 && c <= 13) ? 4'h8 : 4'h0);
            req_is_div = req_val;
            @(negedge clk);
            chk($sformatf("d2_busy_c%0d", c), 32'(div_busy),
                32'((c >= 1 && c <= 12) || (c >= 14 && c <= 25)));
            chk($sformatf("d2_wb_c%0d", c),   32'(wb_div_sel), 32'(c == 12 || c == 25));
            if (c >= 1)
                chk($sformatf("d2_ival_c%0d", c), 32'(issue_val), 32'(c == 13));
            if (c == 13) begin
                chk("d2_idx_c13", 32'(issue_idx),    32'd3);
                chk("d2_isd_c13", 32'(issue_is_div), 32'd1);
            end
        end

        // Flush at 5 with req2 pending: no grant at 5, grant at 6; div still writes back at 12
        pulse_reset();
        for (int c = 0; c <= 13; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            req_val    = (c == 0) ? 4'h2 : ((c == 5 || c == 6) ? 4'h4 : 4'h0);
            req_is_div = (c == 0) ? 4'h2 : 4'h0;
            flush      = (c == 5);
            @(negedge clk);
            chk($sformatf("fl_ival_c%0d", c), 32'(issue_val),  32'(c == 0 || c == 6));
            chk($sformatf("fl_wb_c%0d", c),   32'(wb_div_sel), 32'(c == 12));
            if (c == 6) begin
                chk("fl_gnt_c6", 32'(req_gnt),   32'h4);
                chk("fl_idx_c6", 32'(issue_idx), 32'd2);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
